// File: rtl/dmem_hs.sv
// dmem_hs - handshaked data memory with fixed access latency.
//
// An access is accepted in IDLE when req=1. Address, direction, store data
// and access mode are latched on that edge. The block then spends WAIT cycles
// in WAIT and one cycle in DONE. During DONE, ready pulses for one cycle and
// rd/fault present the response. A store is committed to the array at the
// edge that ends DONE. Requests that arrive while busy=1 are dropped.
//
// Parameters:
//   DEPTH : memory size in 32-bit words (power of two, >= 4)
//   WAIT  : wait cycles between accept and response (0..15)
//
// Ports:
//   clk   : clock, rising-edge active
//   reset : asynchronous active-high reset (the array itself is not cleared)
//   req   : access request, sampled only in IDLE
//   we    : 1 = store, 0 = load
//   a     : byte address; word index = a[log2(DEPTH)+1:2], higher bits ignored
//   wd    : store data, right-aligned
//   mode  : RISC-V funct3 size/sign code
//   rd    : load data, held until the next load response
//   ready : one-cycle response strobe
//   busy  : access in flight
//   fault : illegal (or trapped misaligned) access, valid with ready
//
// Configuration macro DMEM_MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses fault (rd=0, no write)
//   undefined - misaligned addresses are silently aligned down

module dmem_hs #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  mode,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal funct3 codes: stores sb/sh/sw; loads additionally lbu/lhu.
    function automatic logic mode_legal(input logic is_store, input logic [2:0] m);
        logic ok;
        case (m)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] m, input logic [1:0] off);
        logic mis;
        case (m[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] align_off(input logic [2:0] m, input logic [1:0] off);
        logic [1:0] res;
        case (m[1:0])
            2'b01:   res = {off[1], 1'b0};
            2'b10:   res = 2'b00;
            default: res = off;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  m);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (m)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [2:0]  m);
        logic [31:0] res;
        res = old;
        case (m)
            3'b000: res[{off, 3'b000} +: 8] = data[7:0];
            3'b001: begin
                if (off[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0] = data[15:0];
                end
            end
            3'b010:  res = data;
            default: res = old;
        endcase
        return res;
    endfunction

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [AW+1:0]   a_r;
    logic [31:0]     wd_r;
    logic [2:0]      mode_r;
    logic [31:0]     rd_r;
    logic            ready_r;
    logic            busy_r;
    logic            fault_r;
    logic [31:0]     mem_r [DEPTH];

    logic [AW+1:0]   acc_a_s;
    logic            acc_we_s;
    logic [2:0]      acc_mode_s;
    logic [1:0]      off_s;
    logic [31:0]     word_s;
    logic            fault_s;
    logic [31:0]     rd_next_s;
    logic [31:0]     merged_s;
    logic            unused_s;

    assign unused_s = ^a[31:AW+2];

    // Select the access being resolved: live inputs in IDLE (WAIT=0 path), latched copy otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_a_s    = a[AW+1:0];
            acc_we_s   = we;
            acc_mode_s = mode;
        end else begin
            acc_a_s    = a_r;
            acc_we_s   = we_r;
            acc_mode_s = mode_r;
        end
    end

    assign off_s  = align_off(acc_mode_s, acc_a_s[1:0]);
    assign word_s = mem_r[acc_a_s[AW+1:2]];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault_s = !mode_legal(acc_we_s, acc_mode_s) || misaligned(acc_mode_s, acc_a_s[1:0]);
`else
    assign fault_s = !mode_legal(acc_we_s, acc_mode_s);
`endif

    assign merged_s = store_merge(word_s, wd_r, off_s, mode_r);

    // Response data: zero on fault, unchanged for stores, extracted lane for loads.
    always_comb begin
        if (fault_s) begin
            rd_next_s = 32'd0;
        end else if (acc_we_s) begin
            rd_next_s = rd_r;
        end else begin
            rd_next_s = load_extract(word_s, off_s, acc_mode_s);
        end
    end

    // Access FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            a_r     <= '0;
            wd_r    <= 32'd0;
            mode_r  <= 3'd0;
            rd_r    <= 32'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        we_r   <= we;
                        a_r    <= a[AW+1:0];
                        wd_r   <= wd;
                        mode_r <= mode;
                        busy_r <= 1'b1;
                        if (WAIT == 0) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b1;
                            fault_r <= fault_s;
                            rd_r    <= rd_next_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LAST;
                            ready_r <= 1'b0;
                            fault_r <= 1'b0;
                        end
                    end else begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        fault_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b1;
                        fault_r <= fault_s;
                        rd_r    <= rd_next_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    fault_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    fault_r <= 1'b0;
                end
            endcase
        end
    end

    // Commit a legal store at the edge that ends DONE; a reset drops DONE first.
    always_ff @(posedge clk) begin
        if (state_r == ST_DONE && we_r && !fault_s) begin
            mem_r[a_r[AW+1:2]] <= merged_s;
        end
    end

    assign rd    = rd_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign fault = fault_r;

endmodule

// File: tb/tb_dmem_hs.sv
module tb_dmem_hs;

    localparam int DEPTH_C = 1024;
    localparam int WAIT_C  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  mode;
    logic [31:0] rd;
    logic        ready;
    logic        busy;
    logic        fault;

    dmem_hs #(.DEPTH(DEPTH_C), .WAIT(WAIT_C)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .mode  (mode),
        .rd    (rd),
        .ready (ready),
        .busy  (busy),
        .fault (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mdl_mem [DEPTH_C];
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-lane view of memory computed from the access rules.
    task automatic model_access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] m, output logic [31:0] erd, output logic efault);
        int widx;
        int off;
        int nb;
        logic legal;
        logic [31:0] t;
        widx = int'((addr >> 2) % DEPTH_C);
        off  = int'(addr & 32'd3);
        nb   = (m[1:0] == 2'd0) ? 1 : ((m[1:0] == 2'd1) ? 2 : 4);
        legal = w ? (m <= 3'd2) : (m inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        efault = 1'b0;
        if (!legal) begin
            efault = 1'b1;
        end else if ((off % nb) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            efault = 1'b1;
`else
            off = off - (off % nb);
`endif
        end
        if (efault) begin
            erd = 32'd0;
            last_rd = 32'd0;
        end else if (w) begin
            t = mdl_mem[widx];
            for (int i = 0; i < nb; i++) t[8*(off+i) +: 8] = data[8*i +: 8];
            mdl_mem[widx] = t;
            erd = last_rd;
        end else begin
            t = mdl_mem[widx] >> (8 * off);
            if (nb == 1) t = m[2] ? {24'd0, t[7:0]} : {{24{t[7]}}, t[7:0]};
            else if (nb == 2) t = m[2] ? {16'd0, t[15:0]} : {{16{t[15]}}, t[15:0]};
            erd = t;
            last_rd = t;
        end
    endtask

    task automatic wait_idle();
        int g;
        @(negedge clk);
        g = 0;
        while (busy !== 1'b0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] m);
        logic [31:0] erd;
        logic        ef;
        exp_t        e;
        wait_idle();
        we = w; a = addr; wd = data; mode = m; req = 1'b1;
        model_access(w, addr, data, m, erd, ef);
        @(posedge clk);
        #1;
        e.rd = erd; e.fault = ef; e.cyc = cyc;
        q.push_back(e);
        // Scramble inputs after the accept to show they were latched.
        req = 1'b0; we = 1'($urandom); a = $urandom; wd = $urandom; mode = 3'($urandom);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rd", rd, e.rd);
                check("fault", {31'd0, fault}, {31'd0, e.fault});
                // ready is visible after edge accept+WAIT, i.e. sampled at edge accept+WAIT+1
                check("latency", cyc - e.cyc, WAIT_C);
                check("busy_with_ready", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int c0;
        int g;
        logic [31:0] erd;
        logic        ef;
        exp_t        e;

        reset = 1'b1; req = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0; mode = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_rd", rd, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;

        // Give a defined value to the words exercised below.
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 3'b010);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        issue(1'b0, 32'h13, 32'h0, 3'b000);
        issue(1'b0, 32'h13, 32'h0, 3'b100);
        issue(1'b0, 32'h12, 32'h0, 3'b101);
        issue(1'b1, 32'h11, 32'h55, 3'b000);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        issue(1'b0, 32'h22, 32'h0, 3'b010);
        issue(1'b1, 32'h1000, 32'hA5A5A5A5, 3'b010);
        issue(1'b0, 32'h0, 32'h0, 3'b010);
        issue(1'b0, 32'h10, 32'h0, 3'b011);
        issue(1'b1, 32'h4, 32'hFFFFFFFF, 3'b100);
        issue(1'b0, 32'h4, 32'h0, 3'b010);
        issue(1'b1, 32'h7, 32'h0000BEEF, 3'b001);
        issue(1'b0, 32'h4, 32'h0, 3'b010);
        issue(1'b0, 32'h6, 32'h0, 3'b001);

        // Store abandoned by reset while in WAIT.
        wait_idle();
        we = 1'b1; a = 32'h20; wd = 32'h12345678; mode = 3'b010; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_rd", rd, 32'd0);
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_rd = 32'd0;
        issue(1'b0, 32'h20, 32'h0, 3'b010);

        // req held high: one access per WAIT+2 cycles, extras dropped.
        wait_idle();
        we = 1'b0; a = 32'h10; wd = 32'h0; mode = 3'b010; req = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            model_access(1'b0, 32'h10, 32'h0, 3'b010, erd, ef);
            e.rd = erd; e.fault = ef; e.cyc = c0 + 1 + k * (WAIT_C + 2);
            q.push_back(e);
        end
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cnt++;
        end
        @(negedge clk);
        req = 1'b0;
        check("held_busy_cycles", busy_cnt, 30);
        repeat (6) @(negedge clk);
        check("held_responses", q.size(), 0);

        // Random traffic over 16 words, with random aliasing high address bits.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            ra = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            issue(1'($urandom), ra, $urandom, 3'($urandom));
        end

        g = 0;
        while (q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 Parameter DEPTH, default 1024, data memory size in 32-bit words (power of two, >=4).
REQ-002 Parameter WAIT, default 2, wait cycles inserted between request accept and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  access request, sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; qualified by req.
REQ-007 a  input  32  byte address.
REQ-008 wd  input  32  store data, right-aligned.
REQ-009 mode  input  3  RISC-V funct3 access size/sign code.
REQ-010 rd  output  32  load data, sign/zero-extended.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 busy  output  1  access in flight; new requests ignored.
REQ-013 fault  output  1  error flag, valid only while ready=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, DONE: IDLE->WAIT on req=1 (IDLE->DONE if WAIT=0), WAIT->DONE after WAIT cycles, DONE->IDLE unconditionally.
REQ-015 On accept the block SHALL latch a, we, wd, mode; later input changes SHALL NOT affect the access.
REQ-016 ready SHALL be 1 in DONE only, i.e. exactly WAIT+1 cycles after the accepting edge, for one cycle.
REQ-017 busy SHALL be 1 in WAIT and DONE, 0 in IDLE; req while busy=1 SHALL be dropped, not queued.
REQ-018 A new request is acceptable on the cycle after ready (back-to-back throughput = one access per WAIT+2 cycles).
REQ-019 Word index SHALL be a[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH words).
REQ-020 Loads: mode 000 lb sign-extend, 001 lh sign-extend, 010 lw, 100 lbu zero-extend, 101 lhu zero-extend; byte/half selected by a[1:0].
REQ-021 Stores: mode 000 sb, 001 sh, 010 sw; only the addressed byte lanes SHALL change.
REQ-022 Memory write SHALL occur at the rising edge ending DONE; a load issued afterwards SHALL see the new data.
REQ-023 rd SHALL update on entering DONE and hold until the next load response; stores SHALL leave rd unchanged.
REQ-024 Illegal mode (load 011/110/111, store other than 000/001/010) SHALL give fault=1, rd=0, no write.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, rd=0, ready=0, busy=0, fault=0.
REQ-026 Reset during WAIT or DONE SHALL abandon the access; a pending store SHALL NOT be written.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN selects misalignment handling (lh/lhu/sh with a[0]=1; lw/sw with a[1:0]!=0).
REQ-029 Defined: misaligned access SHALL give fault=1 with ready, rd=0, no write.
REQ-030 Undefined: misaligned address SHALL be silently aligned (a[0] cleared for half, a[1:0] cleared for word), fault=0.

Verification
REQ-031 WAIT=2: sw a=0x10 wd=0xDEADBEEF, then lw a=0x10 -> ready 3 cycles after each accept, rd=0xDEADBEEF, fault=0.
REQ-032 After REQ-031: lb a=0x13 -> rd=0xFFFFFFDE; lbu a=0x13 -> 0x000000DE; lhu a=0x12 -> 0x0000DEAD; sb a=0x11 wd=0x55 then lw 0x10 -> 0xDEAD55EF.
REQ-033 req held high continuously with WAIT=2 -> ready every 4th cycle, busy high 3 of 4 cycles, only 1 access per window.
REQ-034 sw a=0x20 wd=0x12345678, reset pulsed in WAIT, then lw 0x20 -> rd equals prior contents, outputs 0 during reset.
REQ-035 lw a=0x22: with DMEM_MISALIGN_TRAP_EN -> fault=1, rd=0; without -> fault=0, rd = word at 0x20.
REQ-036 DEPTH=1024: sw a=0x1000 wd=0xA5A5A5A5, lw a=0x0 -> rd=0xA5A5A5A5 (wrap); load mode 011 -> fault=1, rd=0.
